cordic_hyp_seq: RTL and testbench
=================================

Name: cordic_hyp_seq

Overview:
- Control sequencer for the iterative hyperbolic-CORDIC square-root datapath (X/Y/Z registers, shifters, add/sub units, operand-load muxes).
- Drives the load/feedback mux select, register enables, shift index and rotation direction.
- Inserts the mandatory hyperbolic repeat iterations (i = 4, 13, 40, ...) and provides a start/busy/done handshake to the host.
- Sits between the top-level sqrt wrapper and the datapath. It contains no data arithmetic.

Parameters:
- N_ITER, 16, highest shift index executed (indices run 1..N_ITER); legal range 1..31.
- SHW, 5, width of shift_amt; must satisfy 2^SHW > N_ITER.
- CW, 6, width of step_cnt; must hold N_ITER + number of repeat indices ≤ N_ITER.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new computation; sampled only in IDLE.
- abort  in  1  synchronous abandon of the current computation.
- y_sign  in  1  sign bit (MSB) of the datapath Y register.
- busy  out  1  high in LOAD and ITER.
- done  out  1  one-cycle pulse; the result is valid in the datapath registers.
- sel  out  1  operand mux select: 0 = external operand (load), 1 = feedback path.
- reg_en  out  1  X/Y/Z register write enable.
- shift_amt  out  SHW  current shift index i.
- add_y  out  1  direction: 1 means x+=y>>i, y+=x>>i, z-=atanh; 0 means the opposite signs.
- step_cnt  out  CW  number of ITER steps completed in the current run.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sel=0, reg_en=0, shift_amt=1, add_y=0, step_cnt=0; repeat flag cleared; next_rep=4.
- States and transitions:
  - IDLE -> LOAD when start=1.
  - LOAD -> ITER unconditionally.
  - ITER -> DONE on the final step.
  - DONE -> IDLE unconditionally.
- IDLE: sel=0, reg_en=0, done=0. start while busy is ignored; no queuing.
- LOAD: one cycle; sel=0, reg_en=1 (datapath captures x0=w+0.25, y0=w-0.25). Initialises i=1, rep_flag=0, next_rep=4, step_cnt=0.
- ITER: sel=1, reg_en=1, shift_amt=i, add_y = y_sign (combinational from y_sign in ITER, 0 elsewhere). step_cnt increments each ITER cycle.
- Index update at the end of each ITER cycle:
  - If i==next_rep and rep_flag=0: keep i, set rep_flag.
  - Else if i==next_rep and rep_flag=1: clear rep_flag, next_rep <= 3*next_rep+1, i <= i+1.
  - Else: i <= i+1.
- Final step: i==N_ITER and no repeat pending (i!=next_rep or rep_flag=1). If N_ITER is itself a repeat index, its repeat is executed.
- Total steps S = N_ITER + count of {4,13,40,...} ≤ N_ITER. N_ITER=16 gives S=18; N_ITER=4 gives S=5; N_ITER=3 gives S=3.
- Latency: start high at edge t gives LOAD at t+1, ITER at t+2..t+1+S, and done=1 during cycle t+2+S. Next start is accepted in IDLE at t+3+S. Throughput is one result per S+3 cycles.
- DONE: reg_en=0, sel=1 (holds registers), done=1 for exactly one cycle, busy=0.
- abort=1 in LOAD or ITER: next state IDLE, no done pulse, step_cnt cleared. abort in IDLE/DONE has no effect; DONE still pulses. abort and start together in IDLE: start wins.
- rst asserted mid-run: immediate return to reset values. No done is ever issued for the interrupted run.
- next_rep is kept at SHW+2 bits so 3*next_rep+1 cannot wrap within the legal N_ITER range.

Decomposition:
- Shared package cordic_pkg holds:
  - state encoding (IDLE=0, LOAD=1, ITER=2, DONE=3);
  - FIRST_REP=4;
  - the default N_ITER;
  - a constant function giving S for a given N_ITER, used by both RTL assertions and the bench.
- One natural sub-module: cordic_rep_gen, holding the i / rep_flag / next_rep registers and the final-step detect. The FSM is the parent.

Test Plan:
- Reset then start pulse, N_ITER=16 -> busy from t+1; shift_amt sequence 1,2,3,4,4,5..13,13,14,15,16 (18 ITER cycles); done single pulse at t+20; step_cnt=18 at done.
- y_sign toggled each ITER cycle -> add_y follows y_sign combinationally within the same cycle in ITER; add_y=0 in IDLE/LOAD/DONE.
- start held high continuously -> back-to-back runs; done at t+20, next LOAD at t+22; no start is accepted while busy.
- abort asserted at ITER step 7 -> IDLE next cycle, busy=0, no done, step_cnt=0; a subsequent start gives a full 18-step run.
- rst asserted asynchronously mid-ITER (between edges) -> outputs reach reset values immediately; no done; a normal run follows after rst release.
- N_ITER=4 and N_ITER=13 builds -> shift sequences 1,2,3,4,4 (S=5) and 1..4,4,5..13,13 (S=15); done at t+7 and t+17 respectively.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the hyperbolic-CORDIC sqrt sequencer.
// Holds the FSM state encoding, the first hyperbolic repeat index, the default
// iteration count and a constant function that returns the total number of
// ITER steps (shift indices plus mandatory repeats) for a given N_ITER.
package cordic_pkg;

    localparam int unsigned N_ITER_DEF = 16;
    localparam int unsigned FIRST_REP  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Steps = n_iter + count of {4, 13, 40, ...} <= n_iter.
    // Loop bound is fixed so the function stays a plain constant function.
    function automatic int unsigned num_steps(input int unsigned n_iter);
        int unsigned s;
        int unsigned r;
        s = n_iter;
        r = FIRST_REP;
        for (int k = 0; k < 8; k++) begin
            if (r <= n_iter) begin
                s = s + 1;
                r = 3 * r + 1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/cordic_rep_gen.sv
// Shift-index generator with hyperbolic repeat insertion.
// Ports:
//   clk, rst  - clock, async active-high reset
//   init      - reload i=1, rep_flag=0, next_rep=FIRST_REP
//   adv       - advance the index at the end of this cycle (ITER step)
//   idx       - current shift index i (registered)
//   last_c    - combinational: current step is the final one
import cordic_pkg::*;

module cordic_rep_gen #(
    parameter int unsigned N_ITER = N_ITER_DEF,
    parameter int unsigned SHW    = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           init,
    input  logic           adv,
    output logic [SHW-1:0] idx,
    output logic           last_c
);

    // Two extra bits keep 3*next_rep+1 from wrapping for any legal N_ITER.
    localparam int unsigned RW = SHW + 2;

    logic [RW-1:0] next_rep;
    logic          rep_flag;
    logic          at_rep_c;

    assign at_rep_c = (RW'(idx) == next_rep);

    // Final step: top index reached with no repeat still owed on it.
    assign last_c = (idx == SHW'(N_ITER)) && !(at_rep_c && !rep_flag);

    // Index / repeat bookkeeping; the index is held once the final step is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= SHW'(1);
            rep_flag <= 1'b0;
            next_rep <= RW'(FIRST_REP);
        end else if (init) begin
            idx      <= SHW'(1);
            rep_flag <= 1'b0;
            next_rep <= RW'(FIRST_REP);
        end else if (adv && !last_c) begin
            if (at_rep_c && !rep_flag) begin
                rep_flag <= 1'b1;
            end else if (at_rep_c) begin
                rep_flag <= 1'b0;
                next_rep <= RW'(3) * next_rep + RW'(1);
                idx      <= idx + SHW'(1);
            end else begin
                idx <= idx + SHW'(1);
            end
        end
    end

endmodule

// File: rtl/cordic_hyp_seq.sv
// Control sequencer for the iterative hyperbolic-CORDIC square-root datapath.
// Ports:
//   clk, rst   - clock, async active-high reset
//   start      - begin a computation (sampled in IDLE only)
//   abort      - abandon the current run (LOAD/ITER only)
//   y_sign     - MSB of datapath Y register
//   busy       - high in LOAD and ITER
//   done       - one-cycle pulse when the result is valid
//   sel        - 0 = external operand, 1 = feedback path
//   reg_en     - X/Y/Z register write enable
//   shift_amt  - current shift index i
//   add_y      - rotation direction, follows y_sign during ITER
//   step_cnt   - ITER steps completed in the current run
import cordic_pkg::*;

module cordic_hyp_seq #(
    parameter int unsigned N_ITER = N_ITER_DEF,
    parameter int unsigned SHW    = 5,
    parameter int unsigned CW     = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           y_sign,
    output logic           busy,
    output logic           done,
    output logic           sel,
    output logic           reg_en,
    output logic [SHW-1:0] shift_amt,
    output logic           add_y,
    output logic [CW-1:0]  step_cnt
);

    state_t state_q;
    state_t state_d;
    logic   last_c;
    logic   abort_run_c;

    assign abort_run_c = abort && ((state_q == ST_LOAD) || (state_q == ST_ITER));

    cordic_rep_gen #(
        .N_ITER (N_ITER),
        .SHW    (SHW)
    ) u_rep_gen (
        .clk    (clk),
        .rst    (rst),
        .init   ((state_q == ST_LOAD) || abort_run_c),
        .adv    (state_q == ST_ITER),
        .idx    (shift_amt),
        .last_c (last_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so abort never blocks it there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: state_d = abort ? ST_IDLE : ST_ITER;
            ST_ITER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore output decode; add_y is the one output passed straight through from y_sign.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        sel    = 1'b0;
        reg_en = 1'b0;
        add_y  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                busy   = 1'b1;
                reg_en = 1'b1;
            end
            ST_ITER: begin
                busy   = 1'b1;
                sel    = 1'b1;
                reg_en = 1'b1;
                add_y  = y_sign;
            end
            ST_DONE: begin
                done = 1'b1;
                sel  = 1'b1;
            end
            default: ;
        endcase
    end

    // Step counter: cleared on load or abort, counts every ITER cycle, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if ((state_q == ST_LOAD) || abort_run_c) begin
            step_cnt <= '0;
        end else if (state_q == ST_ITER) begin
            step_cnt <= step_cnt + CW'(1);
        end
    end

    // The run that reaches DONE must have executed exactly the expected step count.
    a_done_steps: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_DONE) |-> (step_cnt == CW'(num_steps(N_ITER))));

endmodule

// File: tb/tb_cordic_hyp_seq.sv
// Directed bench for cordic_hyp_seq: N_ITER=16, 4 and 13 builds side by side.
module tb_cordic_hyp_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic       abort;
    logic       y_sign;

    logic       busy_v   [3];
    logic       done_v   [3];
    logic       sel_v    [3];
    logic       reg_en_v [3];
    logic       add_y_v  [3];
    logic [4:0] shift_v  [3];
    logic [5:0] step_v   [3];

    int total = 0;
    int bad   = 0;

    // Hand-derived shift-index sequences, zero padded to 18 entries.
    int seq_tab [3][18] = '{
        '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16},
        '{1, 2, 3, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 0, 0, 0}
    };

    always #5 clk = ~clk;

    cordic_hyp_seq #(.N_ITER(16), .SHW(5), .CW(6)) dut16 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort), .y_sign(y_sign),
        .busy(busy_v[0]), .done(done_v[0]), .sel(sel_v[0]), .reg_en(reg_en_v[0]),
        .shift_amt(shift_v[0]), .add_y(add_y_v[0]), .step_cnt(step_v[0])
    );

    cordic_hyp_seq #(.N_ITER(4), .SHW(5), .CW(6)) dut4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort), .y_sign(y_sign),
        .busy(busy_v[1]), .done(done_v[1]), .sel(sel_v[1]), .reg_en(reg_en_v[1]),
        .shift_amt(shift_v[1]), .add_y(add_y_v[1]), .step_cnt(step_v[1])
    );

    cordic_hyp_seq #(.N_ITER(13), .SHW(5), .CW(6)) dut13 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort), .y_sign(y_sign),
        .busy(busy_v[2]), .done(done_v[2]), .sel(sel_v[2]), .reg_en(reg_en_v[2]),
        .shift_amt(shift_v[2]), .add_y(add_y_v[2]), .step_cnt(step_v[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run on instance d with S=s steps; called at IDLE, just after an edge.
    task automatic run_full(input int d, input int s);
        logic [3:0] f;
        start_v[d] = 1'b1;
        y_sign     = 1'b1;
        tick();
        start_v[d] = 1'b0;
        f = {busy_v[d], done_v[d], sel_v[d], reg_en_v[d]};
        total++;
        if (f !== 4'b1001) begin
            bad++; $display("FAIL run%0d load_flags got=%b want=1001", d, f);
        end
        total++;
        if (add_y_v[d] !== 1'b0) begin
            bad++; $display("FAIL run%0d load_add_y got=%b want=0", d, add_y_v[d]);
        end
        for (int k = 0; k < s; k++) begin
            tick();
            start_v[d] = (k == 3);
            f = {busy_v[d], done_v[d], sel_v[d], reg_en_v[d]};
            total++;
            if (f !== 4'b1011) begin
                bad++; $display("FAIL run%0d iter%0d_flags got=%b want=1011", d, k, f);
            end
            total++;
            if (shift_v[d] !== 5'(seq_tab[d][k])) begin
                bad++; $display("FAIL run%0d iter%0d_shift got=%0d want=%0d", d, k, shift_v[d], seq_tab[d][k]);
            end
            total++;
            if (step_v[d] !== 6'(k)) begin
                bad++; $display("FAIL run%0d iter%0d_step got=%0d want=%0d", d, k, step_v[d], k);
            end
            y_sign = 1'((k % 2) == 1);
            #1;
            total++;
            if (add_y_v[d] !== 1'((k % 2) == 1)) begin
                bad++; $display("FAIL run%0d iter%0d_add_y got=%b want=%b", d, k, add_y_v[d], (k % 2) == 1);
            end
            y_sign = ~y_sign;
            #1;
            total++;
            if (add_y_v[d] !== 1'((k % 2) == 0)) begin
                bad++; $display("FAIL run%0d iter%0d_add_y_flip got=%b want=%b", d, k, add_y_v[d], (k % 2) == 0);
            end
        end
        start_v[d] = 1'b0;
        y_sign     = 1'b1;
        tick();
        f = {busy_v[d], done_v[d], sel_v[d], reg_en_v[d]};
        total++;
        if (f !== 4'b0110) begin
            bad++; $display("FAIL run%0d done_flags got=%b want=0110", d, f);
        end
        total++;
        if (step_v[d] !== 6'(s)) begin
            bad++; $display("FAIL run%0d done_step got=%0d want=%0d", d, step_v[d], s);
        end
        total++;
        if (add_y_v[d] !== 1'b0) begin
            bad++; $display("FAIL run%0d done_add_y got=%b want=0", d, add_y_v[d]);
        end
        tick();
        f = {busy_v[d], done_v[d], sel_v[d], reg_en_v[d]};
        total++;
        if (f !== 4'b0000) begin
            bad++; $display("FAIL run%0d idle_flags got=%b want=0000", d, f);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start_v = 3'b000;
        abort   = 1'b0;
        y_sign  = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({busy_v[d], done_v[d], sel_v[d], reg_en_v[d], add_y_v[d]} !== 5'b00000) begin
                bad++; $display("FAIL reset%0d_flags got=%b want=00000", d,
                                {busy_v[d], done_v[d], sel_v[d], reg_en_v[d], add_y_v[d]});
            end
            total++;
            if (shift_v[d] !== 5'd1) begin
                bad++; $display("FAIL reset%0d_shift got=%0d want=1", d, shift_v[d]);
            end
            total++;
            if (step_v[d] !== 6'd0) begin
                bad++; $display("FAIL reset%0d_step got=%0d want=0", d, step_v[d]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    // start held high: LOAD at c=1 and c=22, DONE at c=20 and c=41.
    task automatic test_back_to_back();
        int      ph;
        logic [1:0] want;
        start_v[0] = 1'b1;
        y_sign     = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            tick();
            ph   = (c - 1) % 21;
            want = (ph <= 18) ? 2'b10 : ((ph == 19) ? 2'b01 : 2'b00);
            total++;
            if ({busy_v[0], done_v[0]} !== want) begin
                bad++; $display("FAIL b2b_c%0d busy_done got=%b want=%b", c, {busy_v[0], done_v[0]}, want);
            end
            if (ph >= 1 && ph <= 18) begin
                total++;
                if (shift_v[0] !== 5'(seq_tab[0][ph-1])) begin
                    bad++; $display("FAIL b2b_c%0d shift got=%0d want=%0d", c, shift_v[0], seq_tab[0][ph-1]);
                end
            end
        end
        start_v[0] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_abort();
        bit seen;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        total++;
        if (shift_v[0] !== 5'd6) begin
            bad++; $display("FAIL abort_pre_shift got=%0d want=6", shift_v[0]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({busy_v[0], done_v[0], sel_v[0], reg_en_v[0]} !== 4'b0000) begin
            bad++; $display("FAIL abort_idle_flags got=%b want=0000", {busy_v[0], done_v[0], sel_v[0], reg_en_v[0]});
        end
        total++;
        if (step_v[0] !== 6'd0) begin
            bad++; $display("FAIL abort_step got=%0d want=0", step_v[0]);
        end
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done_v[0] || busy_v[0]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL abort_no_done got=%b want=0", seen);
        end
        // start and abort together in IDLE: start wins; then abort out of LOAD.
        start_v[0] = 1'b1;
        abort      = 1'b1;
        tick();
        start_v[0] = 1'b0;
        total++;
        if ({busy_v[0], reg_en_v[0], sel_v[0]} !== 3'b110) begin
            bad++; $display("FAIL abort_start_wins got=%b want=110", {busy_v[0], reg_en_v[0], sel_v[0]});
        end
        tick();
        abort = 1'b0;
        total++;
        if ({busy_v[0], done_v[0]} !== 2'b00) begin
            bad++; $display("FAIL abort_in_load got=%b want=00", {busy_v[0], done_v[0]});
        end
        run_full(0, 18);
    endtask

    task automatic test_async_reset();
        bit seen;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        y_sign = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({busy_v[0], done_v[0], sel_v[0], reg_en_v[0], add_y_v[0]} !== 5'b00000) begin
            bad++; $display("FAIL arst_flags got=%b want=00000",
                            {busy_v[0], done_v[0], sel_v[0], reg_en_v[0], add_y_v[0]});
        end
        total++;
        if (shift_v[0] !== 5'd1 || step_v[0] !== 6'd0) begin
            bad++; $display("FAIL arst_shift_step got=%0d/%0d want=1/0", shift_v[0], step_v[0]);
        end
        tick();
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done_v[0] || busy_v[0]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL arst_no_done got=%b want=0", seen);
        end
        run_full(0, 18);
    endtask

    task automatic test_short_builds();
        run_full(1, 5);
        tick();
        run_full(2, 15);
    endtask

    initial begin
        test_reset();
        run_full(0, 18);
        tick();
        test_back_to_back();
        test_abort();
        tick();
        test_async_reset();
        tick();
        test_short_builds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
